// File: rtl/hub75_rx_pkg.sv
// Shared types for the HUB75 receiver: FSM encoding and blank-measure counter width.
package hub75_rx_pkg;
  typedef enum logic {ST_SHIFT = 1'b0, ST_LATCH = 1'b1} state_e;
  localparam int ON_TIME_W = 16;
endpackage

// File: rtl/hub75_rx_sync.sv
// Multi-stage synchroniser for asynchronous pad inputs, with per-bit reset value.
module hub75_rx_sync #(
  parameter int           W       = 1,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = {pipe_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= RST_VAL;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign q = pipe_q[STAGES-1];
endmodule

// File: rtl/hub75_rx.sv
// HUB75 oversampling receiver: rebuilds column shifts and row latches from pads.
// Optional HUB75_RX_BLANK_MEAS_EN adds per-line blank-low (on-time) measurement.
module hub75_rx
  import hub75_rx_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int N_CHANS     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS),
  parameter int DW          = N_BANKS * N_CHANS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LOG_N_ROWS-1:0] hub75_addr,
  input  logic [DW-1:0]         hub75_data,
  input  logic                  hub75_clk,
  input  logic                  hub75_le,
  input  logic                  hub75_blank,
  output logic                  pw_valid,
  output logic [LOG_N_COLS-1:0] pw_col,
  output logic [DW-1:0]         pw_data,
  output logic                  le_valid,
  output logic [LOG_N_ROWS-1:0] le_row,
  output logic [LOG_N_COLS:0]   le_ncols,
  output logic                  err_len,
`ifdef HUB75_RX_BLANK_MEAS_EN
  output logic                  on_valid,
  output logic [LOG_N_ROWS-1:0] on_row,
  output logic [ON_TIME_W-1:0]  on_time,
`endif
  input  logic                  err_clr
);
  localparam int                CW      = LOG_N_COLS + 1;
  localparam logic [CW-1:0]     COL_MAX = '1;

  logic [DW-1:0]         data_s;
  logic [LOG_N_ROWS-1:0] addr_s;
  logic                  clk_s, le_s;

  // clk, le, addr, data all see the same synchroniser depth so they stay aligned
  hub75_rx_sync #(.W(DW), .STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d(hub75_data), .q(data_s));
  hub75_rx_sync #(.W(LOG_N_ROWS), .STAGES(SYNC_STAGES)) u_sync_addr (
    .clk(clk), .rst_n(rst_n), .d(hub75_addr), .q(addr_s));
  hub75_rx_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync_ctrl (
    .clk(clk), .rst_n(rst_n), .d({hub75_le, hub75_clk}), .q({le_s, clk_s}));

  state_e state_q, state_d;
  logic   clk_prev_q, le_prev_q;
  logic   clk_rise, le_rise, le_fall, shift, latch;
  logic [CW-1:0]         col_cnt_q, col_cnt_d, col_inc, col_now;
  logic                  pw_valid_q, pw_valid_d, le_valid_q, le_valid_d, err_q, err_d;
  logic [LOG_N_COLS-1:0] pw_col_q, pw_col_d;
  logic [DW-1:0]         pw_data_q, pw_data_d;
  logic [LOG_N_ROWS-1:0] le_row_q, le_row_d;
  logic [CW-1:0]         le_ncols_q, le_ncols_d;

  assign clk_rise = clk_s & ~clk_prev_q;
  assign le_rise  = le_s & ~le_prev_q;
  assign le_fall  = ~le_s & le_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SHIFT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SHIFT: if (le_rise) state_d = ST_LATCH;
      ST_LATCH: if (le_fall) state_d = ST_SHIFT;
      default:               state_d = ST_SHIFT;
    endcase
  end

  // A clock edge coincident with the latch edge is counted before the latch
  always_comb begin
    shift      = (state_q == ST_SHIFT) && clk_rise;
    latch      = (state_q == ST_SHIFT) && le_rise;
    col_inc    = (col_cnt_q == COL_MAX) ? col_cnt_q : col_cnt_q + 1'b1;
    col_now    = shift ? col_inc : col_cnt_q;
    col_cnt_d  = latch ? '0 : col_now;
    pw_valid_d = shift;
    pw_col_d   = shift ? col_cnt_q[LOG_N_COLS-1:0] : pw_col_q;
    pw_data_d  = shift ? data_s : pw_data_q;
    le_valid_d = latch;
    le_row_d   = latch ? addr_s : le_row_q;
    le_ncols_d = latch ? col_now : le_ncols_q;
    err_d      = err_clr ? 1'b0 : err_q;
    if (latch && (col_now != CW'(N_COLS))) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q <= 1'b0;
      le_prev_q  <= 1'b0;
      col_cnt_q  <= '0;
      pw_valid_q <= 1'b0;
      pw_col_q   <= '0;
      pw_data_q  <= '0;
      le_valid_q <= 1'b0;
      le_row_q   <= '0;
      le_ncols_q <= '0;
      err_q      <= 1'b0;
    end else begin
      clk_prev_q <= clk_s;
      le_prev_q  <= le_s;
      col_cnt_q  <= col_cnt_d;
      pw_valid_q <= pw_valid_d;
      pw_col_q   <= pw_col_d;
      pw_data_q  <= pw_data_d;
      le_valid_q <= le_valid_d;
      le_row_q   <= le_row_d;
      le_ncols_q <= le_ncols_d;
      err_q      <= err_d;
    end
  end

  assign pw_valid = pw_valid_q;
  assign pw_col   = pw_col_q;
  assign pw_data  = pw_data_q;
  assign le_valid = le_valid_q;
  assign le_row   = le_row_q;
  assign le_ncols = le_ncols_q;
  assign err_len  = err_q;

`ifdef HUB75_RX_BLANK_MEAS_EN
  localparam logic [ON_TIME_W-1:0] ON_MAX = '1;
  logic                  blank_s, blank_prev_q, blank_rise;
  logic [ON_TIME_W-1:0]  on_cnt_q, on_cnt_d, on_time_q, on_time_d;
  logic                  on_valid_q, on_valid_d;
  logic [LOG_N_ROWS-1:0] on_row_q, on_row_d;

  // blank resets high (dark) so release never looks like a blank edge
  hub75_rx_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_blank (
    .clk(clk), .rst_n(rst_n), .d(hub75_blank), .q(blank_s));

  always_comb begin
    blank_rise = blank_s & ~blank_prev_q;
    on_cnt_d   = on_cnt_q;
    if (blank_rise)                      on_cnt_d = '0;
    else if (!blank_s && on_cnt_q != ON_MAX) on_cnt_d = on_cnt_q + 1'b1;
    on_valid_d = blank_rise;
    on_row_d   = blank_rise ? le_row_q : on_row_q;
    on_time_d  = blank_rise ? on_cnt_q : on_time_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_prev_q <= 1'b1;
      on_cnt_q     <= '0;
      on_valid_q   <= 1'b0;
      on_row_q     <= '0;
      on_time_q    <= '0;
    end else begin
      blank_prev_q <= blank_s;
      on_cnt_q     <= on_cnt_d;
      on_valid_q   <= on_valid_d;
      on_row_q     <= on_row_d;
      on_time_q    <= on_time_d;
    end
  end

  assign on_valid = on_valid_q;
  assign on_row   = on_row_q;
  assign on_time  = on_time_q;
`endif
endmodule
